// File: rtl/encoder_8_3_scan.sv
// Sequential 8-to-3 priority encoder: captures a request vector and emits the
// index of every set bit, one per valid/ready transfer, then pulses done.
module encoder_8_3_scan #(
    parameter int HIGH_FIRST = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       load,
    input  logic       ready,
    output logic [2:0] code,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic       empty
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [7:0] pending, pending_n;
    logic [2:0] code_n;
    logic       valid_n, busy_n, done_n, empty_n;
    logic [7:0] remaining;

    // Index of the bit that is serviced next under the configured priority.
    function automatic logic [2:0] prio_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (HIGH_FIRST != 0) begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    assign remaining = pending & ~(8'b1 << code);

    always_comb begin
        state_n   = state;
        pending_n = pending;
        code_n    = code;
        valid_n   = valid;
        busy_n    = busy;
        done_n    = 1'b0;
        empty_n   = 1'b0;
        case (state)
            S_IDLE: begin
                valid_n = 1'b0;
                busy_n  = 1'b0;
                if (load) begin
                    busy_n = 1'b1;
                    if (req != 8'h00) begin
                        pending_n = req;
                        code_n    = prio_idx(req);
                        valid_n   = 1'b1;
                        state_n   = S_SCAN;
                    end else begin
                        done_n  = 1'b1;
                        empty_n = 1'b1;
                        state_n = S_DONE;
                    end
                end
            end
            S_SCAN: begin
                // code is already registered, so a transfer only has to look one bit ahead.
                if (valid && ready) begin
                    pending_n = remaining;
                    if (remaining != 8'h00) begin
                        code_n = prio_idx(remaining);
                    end else begin
                        valid_n = 1'b0;
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                valid_n = 1'b0;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                valid_n   = 1'b0;
                busy_n    = 1'b0;
                pending_n = 8'h00;
                state_n   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            pending <= 8'h00;
            code    <= 3'd0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            empty   <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            code    <= code_n;
            valid   <= valid_n;
            busy    <= busy_n;
            done    <= done_n;
            empty   <= empty_n;
        end
    end

endmodule

// File: tb/tb_encoder_8_3_scan.sv
// Bench for encoder_8_3_scan: one instance per priority order, shared stimulus,
// expected index sequences built from the request vector with plain loops.
module tb_encoder_8_3_scan;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       load;
    logic       ready;
    logic [2:0] code_o  [2];
    logic       valid_o [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic       empty_o [2];

    int checks = 0;
    int errors = 0;

    // Observation state filled by run_scan; sequences are 4 bits per code with a marker bit.
    logic [31:0] seq_hi, seq_lo;
    logic [63:0] dec_seq;
    int          busy_cycles, done_cnt;
    bit          empty_seen, any_valid, valid_in_done, tail_ok, timed_out;

    encoder_8_3_scan #(.HIGH_FIRST(1)) dut_hi (
        .clk(clk), .reset(reset), .req(req), .load(load), .ready(ready),
        .code(code_o[1]), .valid(valid_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .empty(empty_o[1])
    );

    encoder_8_3_scan #(.HIGH_FIRST(0)) dut_lo (
        .clk(clk), .reset(reset), .req(req), .load(load), .ready(ready),
        .code(code_o[0]), .valid(valid_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .empty(empty_o[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_seq(input logic [7:0] r, input bit high_first);
        logic [31:0] s;
        s = 32'h0;
        for (int k = 0; k < 8; k++) begin
            int i;
            i = high_first ? 7 - k : k;
            if (r[i]) s = (s << 4) | 32'(8 + i);
        end
        return s;
    endfunction

    function automatic int popcount8(input logic [7:0] r);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(r[i]);
        return n;
    endfunction

    function automatic logic [6:0] outs(input int k);
        return {code_o[k], valid_o[k], busy_o[k], done_o[k], empty_o[k]};
    endfunction

    // Drives one scan from IDLE (or continues one already loaded) until done has
    // been seen and one further edge has passed. Called at posedge+1.
    task automatic run_scan(input logic [7:0] r, input int ready_pct,
                            input int inject_at, input bit do_load);
        bit fin;
        int cyc;
        seq_hi = 0; seq_lo = 0; dec_seq = 0;
        busy_cycles = 0; done_cnt = 0;
        empty_seen = 0; any_valid = 0; valid_in_done = 0; tail_ok = 0; timed_out = 0;
        if (do_load) begin
            req  = r;
            load = 1'b1;
            @(posedge clk); #1;
            load = 1'b0;
            req  = 8'($urandom);
        end
        fin = 0;
        cyc = 0;
        while (!fin && cyc < 200) begin
            load = (cyc == inject_at);
            if (cyc == inject_at) req = 8'hFF;
            ready = ($urandom_range(0, 99) < ready_pct);
            if (busy_o[1]) busy_cycles++;
            any_valid |= valid_o[1] | valid_o[0];
            dec_seq = (dec_seq << 8) | 64'(valid_o[1] ? (8'b1 << code_o[1]) : 8'h00);
            if (valid_o[1] && ready) seq_hi = (seq_hi << 4) | 32'({1'b1, code_o[1]});
            if (valid_o[0] && ready) seq_lo = (seq_lo << 4) | 32'({1'b1, code_o[0]});
            if (done_o[1]) begin
                done_cnt++;
                empty_seen    = empty_o[1];
                valid_in_done = valid_o[1];
            end
            @(posedge clk); #1;
            load = 1'b0;
            if (done_cnt > 0) begin
                tail_ok = !done_o[1] && !busy_o[1] && !done_o[0] && !busy_o[0];
                fin = 1;
            end
            cyc++;
        end
        timed_out = !fin;
    endtask

    task automatic test_reset;
        reset = 1'b1; load = 1'b0; ready = 1'b0; req = 8'h00;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (outs(k) !== 7'h00) begin
                errors++;
                $display("FAIL reset_init[%0d]: got %h, expected %h", k, outs(k), 7'h00);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        req = 8'hA5; load = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #1;
        #3;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (outs(k) !== 7'h00) begin
                errors++;
                $display("FAIL reset_async[%0d]: got %h, expected %h", k, outs(k), 7'h00);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy_o[1], valid_o[1], done_o[1], busy_o[0], valid_o[0], done_o[0]} !== 6'b0) begin
            errors++;
            $display("FAIL reset_release: busy/valid/done hi=%b%b%b lo=%b%b%b, expected zeros",
                     busy_o[1], valid_o[1], done_o[1], busy_o[0], valid_o[0], done_o[0]);
        end
    endtask

    task automatic test_full_scan;
        run_scan(8'b1010_0101, 100, -1, 1);
        checks++;
        if (seq_hi !== 32'hFDA8 || timed_out) begin
            errors++;
            $display("FAIL full_scan_codes: got %h, expected %h", seq_hi, 32'hFDA8);
        end
        checks++;
        if (busy_cycles != 5 || done_cnt != 1 || !tail_ok || valid_in_done) begin
            errors++;
            $display("FAIL full_scan_timing: busy=%0d done=%0d tail=%0b vdone=%0b, expected 5 1 1 0",
                     busy_cycles, done_cnt, tail_ok, valid_in_done);
        end
    endtask

    task automatic test_backpressure;
        req = 8'b0001_1000; load = 1'b1; ready = 1'b0;
        @(posedge clk); #1;
        load = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (code_o[1] !== 3'd4 || valid_o[1] !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: code=%0d valid=%b, expected 4 1",
                         c, code_o[1], valid_o[1]);
            end
            @(posedge clk); #1;
        end
        run_scan(8'h00, 100, -1, 0);
        checks++;
        if (seq_hi !== 32'hCB || done_cnt != 1 || timed_out) begin
            errors++;
            $display("FAIL backpressure_codes: got %h done=%0d, expected %h done=1", seq_hi, done_cnt, 32'hCB);
        end
    endtask

    task automatic test_empty;
        run_scan(8'h00, 100, -1, 1);
        checks++;
        if (done_cnt != 1 || !empty_seen || any_valid || busy_cycles != 1 || !tail_ok) begin
            errors++;
            $display("FAIL empty_load: done=%0d empty=%0b valid_seen=%0b busy=%0d tail=%0b, expected 1 1 0 1 1",
                     done_cnt, empty_seen, any_valid, busy_cycles, tail_ok);
        end
    endtask

    task automatic test_ignored_load;
        run_scan(8'b1000_0100, 100, 1, 1);
        checks++;
        if (seq_hi !== 32'hFA || seq_lo !== 32'hAF || done_cnt != 1) begin
            errors++;
            $display("FAIL ignored_load: hi=%h lo=%h done=%0d, expected fa af 1", seq_hi, seq_lo, done_cnt);
        end
    endtask

    task automatic test_low_first;
        run_scan(8'hFF, 100, -1, 1);
        checks++;
        if (seq_lo !== 32'h89ABCDEF || done_cnt != 1 || busy_cycles != 9) begin
            errors++;
            $display("FAIL low_first_all: got %h busy=%0d, expected 89abcdef busy=9", seq_lo, busy_cycles);
        end
    endtask

    task automatic test_decoder;
        run_scan(8'b0100_0010, 100, -1, 1);
        checks++;
        if (dec_seq !== 64'h400200) begin
            errors++;
            $display("FAIL decoder_roundtrip: got %h, expected %h", dec_seq, 64'h400200);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 25; it++) begin
            logic [7:0] r;
            int pct;
            r   = (it % 5 == 0) ? 8'h00 : 8'($urandom);
            pct = $urandom_range(20, 100);
            run_scan(r, pct, $urandom_range(0, 3), 1);
            checks++;
            if (seq_hi !== model_seq(r, 1'b1) || seq_lo !== model_seq(r, 1'b0)) begin
                errors++;
                $display("FAIL random_codes req=%h: hi=%h lo=%h, expected %h %h",
                         r, seq_hi, seq_lo, model_seq(r, 1'b1), model_seq(r, 1'b0));
            end
            checks++;
            if (done_cnt != 1 || empty_seen != (r == 8'h00) || !tail_ok || timed_out) begin
                errors++;
                $display("FAIL random_done req=%h: done=%0d empty=%0b tail=%0b timeout=%0b",
                         r, done_cnt, empty_seen, tail_ok, timed_out);
            end
            if (pct == 100) begin
                checks++;
                if (busy_cycles != popcount8(r) + 1) begin
                    errors++;
                    $display("FAIL random_busy req=%h: got %0d, expected %0d", r, busy_cycles, popcount8(r) + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_full_scan;
        test_backpressure;
        test_empty;
        test_ignored_load;
        test_low_first;
        test_decoder;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
